// File: rtl/cu_pkg.sv
// Shared definitions for the operational unit: control-word layout and ALU opcodes.
package cu_pkg;

  localparam int CW_WIDTH = 32'd17;

  // Control-word field positions
  localparam int CW_ALU_OP_HI = 32'd16;
  localparam int CW_ALU_OP_LO = 32'd14;
  localparam int CW_DST_HI    = 32'd13;
  localparam int CW_DST_LO    = 32'd12;
  localparam int CW_SRC_A_HI  = 32'd11;
  localparam int CW_SRC_A_LO  = 32'd10;
  localparam int CW_SRC_B_HI  = 32'd9;
  localparam int CW_SRC_B_LO  = 32'd8;
  localparam int CW_REG_WE    = 32'd7;
  localparam int CW_FLAG_WE   = 32'd6;
  localparam int CW_IMM_SEL   = 32'd5;
  localparam int CW_LOAD      = 32'd4;
  localparam int CW_STORE     = 32'd3;
  localparam int CW_IMM_HI    = 32'd2;
  localparam int CW_IMM_LO    = 32'd0;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b101;
  localparam logic [2:0] ALU_SHL  = 3'b110;
  localparam logic [2:0] ALU_SHR  = 3'b111;

endpackage

// File: rtl/operational_unit_if.sv
// Bus between the control unit (master) and the operational unit (slave).
interface operational_unit_if #(
  parameter int DATA_WIDTH = 8
);
  import cu_pkg::*;

  logic [CW_WIDTH-1:0]   control_bus;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  out_strobe;
  logic                  carry_flag;
  logic                  zero_flag;

  modport master (
    output control_bus, data_in,
    input  data_out, out_strobe, carry_flag, zero_flag
  );

  modport slave (
    input  control_bus, data_in,
    output data_out, out_strobe, carry_flag, zero_flag
  );

endinterface

// File: rtl/datapath_alu.sv
// Combinational ALU; arithmetic is one bit wider than the data so the top bit is carry/borrow.
module datapath_alu import cu_pkg::*; #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [2:0]            op,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] r,
  output logic                  c
);

  logic [DATA_WIDTH:0] wide_s;
  logic [DATA_WIDTH:0] cin_ext_s;

  assign cin_ext_s = {{DATA_WIDTH{1'b0}}, cin};

  // Opcode decode; for SUB the wrapped top bit is the borrow
  always_comb begin
    wide_s = {(DATA_WIDTH + 1){1'b0}};
    case (op)
      ALU_PASS: wide_s = {1'b0, a};
      ALU_ADD:  wide_s = {1'b0, a} + {1'b0, b} + cin_ext_s;
      ALU_SUB:  wide_s = {1'b0, a} - {1'b0, b} - cin_ext_s;
      ALU_AND:  wide_s = {1'b0, a & b};
      ALU_OR:   wide_s = {1'b0, a | b};
      ALU_XOR:  wide_s = {1'b0, a ^ b};
      ALU_SHL:  wide_s = {a, 1'b0};
      ALU_SHR:  wide_s = {a[0], 1'b0, a[DATA_WIDTH-1:1]};
      default:  wide_s = {(DATA_WIDTH + 1){1'b0}};
    endcase
  end

  assign r = wide_s[DATA_WIDTH-1:0];
  assign c = wide_s[DATA_WIDTH];

endmodule

// File: rtl/operational_unit.sv
// Microcoded datapath: 4-entry register file, ALU, flags and store latch.
// Optional OPERATIONAL_UNIT_CARRY_CHAIN_EN feeds carry_flag into ADD/SUB as carry-in.
module operational_unit import cu_pkg::*; #(
  parameter int DATA_WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  operational_unit_if.slave  bus
);

  logic [DATA_WIDTH-1:0] regs_r [4];
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  out_strobe_r;
  logic                  carry_flag_r;
  logic                  zero_flag_r;

  logic [2:0]            alu_op_s;
  logic [1:0]            dst_s;
  logic [1:0]            src_a_s;
  logic [1:0]            src_b_s;
  logic                  reg_we_s;
  logic                  flag_we_s;
  logic                  imm_sel_s;
  logic                  load_s;
  logic                  store_s;
  logic [2:0]            imm_s;

  logic [DATA_WIDTH-1:0] operand_a_s;
  logic [DATA_WIDTH-1:0] operand_b_s;
  logic [DATA_WIDTH-1:0] alu_r_s;
  logic                  alu_c_s;
  logic                  cin_s;
  logic [DATA_WIDTH-1:0] write_data_s;

  assign alu_op_s  = bus.control_bus[CW_ALU_OP_HI:CW_ALU_OP_LO];
  assign dst_s     = bus.control_bus[CW_DST_HI:CW_DST_LO];
  assign src_a_s   = bus.control_bus[CW_SRC_A_HI:CW_SRC_A_LO];
  assign src_b_s   = bus.control_bus[CW_SRC_B_HI:CW_SRC_B_LO];
  assign reg_we_s  = bus.control_bus[CW_REG_WE];
  assign flag_we_s = bus.control_bus[CW_FLAG_WE];
  assign imm_sel_s = bus.control_bus[CW_IMM_SEL];
  assign load_s    = bus.control_bus[CW_LOAD];
  assign store_s   = bus.control_bus[CW_STORE];
  assign imm_s     = bus.control_bus[CW_IMM_HI:CW_IMM_LO];

`ifdef OPERATIONAL_UNIT_CARRY_CHAIN_EN
  assign cin_s = carry_flag_r;
`else
  assign cin_s = 1'b0;
`endif

  // Operand and write-back selection from pre-edge register values
  always_comb begin
    operand_a_s  = regs_r[src_a_s];
    operand_b_s  = regs_r[src_b_s];
    write_data_s = alu_r_s;
    if (imm_sel_s) begin
      operand_b_s = {{(DATA_WIDTH - 3){1'b0}}, imm_s};
    end else begin
      operand_b_s = regs_r[src_b_s];
    end
    if (load_s) begin
      write_data_s = bus.data_in;
    end else begin
      write_data_s = alu_r_s;
    end
  end

  datapath_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a   (operand_a_s),
    .b   (operand_b_s),
    .op  (alu_op_s),
    .cin (cin_s),
    .r   (alu_r_s),
    .c   (alu_c_s)
  );

  // Register file write port
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs_r[0] <= {DATA_WIDTH{1'b0}};
      regs_r[1] <= {DATA_WIDTH{1'b0}};
      regs_r[2] <= {DATA_WIDTH{1'b0}};
      regs_r[3] <= {DATA_WIDTH{1'b0}};
    end else if (reg_we_s) begin
      regs_r[dst_s] <= write_data_s;
    end
  end

  // Flags always reflect the ALU, even when the register write takes data_in
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      carry_flag_r <= 1'b0;
      zero_flag_r  <= 1'b0;
    end else if (flag_we_s) begin
      carry_flag_r <= alu_c_s;
      zero_flag_r  <= (alu_r_s == {DATA_WIDTH{1'b0}});
    end
  end

  // Store latch samples the old register value, so a same-cycle write is not seen
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out_r   <= {DATA_WIDTH{1'b0}};
      out_strobe_r <= 1'b0;
    end else begin
      out_strobe_r <= store_s;
      if (store_s) begin
        data_out_r <= operand_a_s;
      end
    end
  end

  assign bus.data_out   = data_out_r;
  assign bus.out_strobe = out_strobe_r;
  assign bus.carry_flag = carry_flag_r;
  assign bus.zero_flag  = zero_flag_r;

endmodule
